// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory access arbiter.
// Holds the outstanding-read state, the grant source and the address legality check.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PEND  = 2'd1,
    ERR_PEND = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_LOAD  = 2'd1,
    GNT_FETCH = 2'd2
  } grant_src_e;

  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_size);
    return (addr[1:0] == 2'b00) && (addr < mem_size);
  endfunction

endpackage

// File: rtl/imem_grant_logic.sv
// Loader-priority grant decision with a starvation bound that forces one fetch grant
// after max_load_burst consecutive loader grants while a fetch is waiting.
module imem_grant_logic
  import imem_arbiter_pkg::*;
#(
  parameter int max_load_burst = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fetch_req,
  input  logic       load_req,
  output logic       fetch_grant,
  output logic       load_grant,
  output grant_src_e gnt_src
);

  localparam int CW = $clog2(max_load_burst + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(max_load_burst);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    gnt_src     = GNT_NONE;
    burst_cnt_d = burst_cnt_q;
    // Grants are masked while reset is asserted so every output reads zero.
    if (reset_n) begin
      if (load_req && ((burst_cnt_q < BURST_MAX) || !fetch_req)) begin
        gnt_src = GNT_LOAD;
      end else if (fetch_req) begin
        gnt_src = GNT_FETCH;
      end
    end
    if (!fetch_req || (gnt_src == GNT_FETCH)) begin
      burst_cnt_d = '0;
    end else if ((gnt_src == GNT_LOAD) && (burst_cnt_q < BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign load_grant  = (gnt_src == GNT_LOAD);
  assign fetch_grant = (gnt_src == GNT_FETCH);

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the single-port instruction memory between core fetch (read) and the program
// loader (write); drives the memory directly and returns fetch data one cycle after grant.
module imem_access_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int memory_size         = 1024,
  parameter int memory_address_bits = $clog2(memory_size),
  parameter int max_load_burst      = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           fetch_req,
  input  logic [31:0]                    fetch_pc,
  output logic                           fetch_grant,
  output logic                           fetch_valid,
  output logic [31:0]                    fetch_instr,
  output logic                           fetch_error,
  input  logic                           load_req,
  input  logic [31:0]                    load_addr,
  input  logic [31:0]                    load_data,
  output logic                           load_grant,
  output logic                           load_error,
  output logic                           mem_write_enable,
  output logic                           mem_read_enable,
  output logic [memory_address_bits-3:0] mem_address,
  output logic [31:0]                    mem_input_data,
  input  logic [31:0]                    mem_output_data
);

  localparam int AW = memory_address_bits - 2;

  grant_src_e    gnt_src;
  rd_state_e     rd_state_q, rd_state_d;
  logic          load_err_q, load_err_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic          fetch_legal, load_legal;

  imem_grant_logic #(
    .max_load_burst(max_load_burst)
  ) u_grant (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .load_req   (load_req),
    .fetch_grant(fetch_grant),
    .load_grant (load_grant),
    .gnt_src    (gnt_src)
  );

  assign fetch_legal = addr_legal(fetch_pc, memory_size);
  assign load_legal  = addr_legal(load_addr, memory_size);

  always_comb begin
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_address      = mem_address_q;
    mem_input_data   = '0;
    rd_state_d       = IDLE;
    load_err_d       = 1'b0;
    // Illegal grants complete the handshake but never touch the memory.
    case (gnt_src)
      GNT_LOAD: begin
        load_err_d = !load_legal;
        if (load_legal) begin
          mem_write_enable = 1'b1;
          mem_address      = load_addr[memory_address_bits-1:2];
          mem_input_data   = load_data;
        end
      end
      GNT_FETCH: begin
        rd_state_d = fetch_legal ? RD_PEND : ERR_PEND;
        if (fetch_legal) begin
          mem_read_enable = 1'b1;
          mem_address     = fetch_pc[memory_address_bits-1:2];
        end
      end
      default: ;
    endcase
    mem_address_d = mem_address;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q    <= IDLE;
      load_err_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      rd_state_q    <= rd_state_d;
      load_err_q    <= load_err_d;
      mem_address_q <= mem_address_d;
    end
  end

  assign fetch_valid = (rd_state_q != IDLE);
  assign fetch_error = (rd_state_q == ERR_PEND);
  assign fetch_instr = (rd_state_q == RD_PEND) ? mem_output_data : '0;
  assign load_error  = load_err_q;

endmodule
